// File: rtl/uart_rx.sv
// Asynchronous 8N1 (optionally 8E1/8O1 via UART_RX_PARITY_EN) serial receiver, LSB first.
// Latency: result pulse 3 cycles after the mid-stop-bit point on uart_rxd (2 sync + 1 register).
// Backpressure: none; each good byte is a one-cycle uart_rx_valid pulse, uart_rx_data held until the next.
module uart_rx #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8,
   parameter int PARITY_ODD   = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic                    uart_rx_valid,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data,
   output logic                    uart_rx_frame_err,
   output logic                    uart_rx_break,
   output logic                    uart_rx_parity_err
);

   localparam int CPB = CLK_HZ / BIT_RATE;
   localparam int CW  = $clog2(CPB);
   localparam int BW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS - 1);

   // Reject configurations the bit timing cannot resolve.
   if (CPB < 4 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_cfg_check
      $error("uart_rx: CLK_HZ/BIT_RATE must be >= 4 and PARITY_ODD 0 or 1");
   end

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic PAR_SENSE = 1'(PARITY_ODD);
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t                  state_q, state_d;
   logic                    rxd_meta_q, rxd_s_q, rxd_prev_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic [PAYLOAD_BITS-1:0] data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    ferr_q, ferr_d;
   logic                    brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
   logic                    perr_q, perr_d;
   logic                    par_bad_q, par_bad_d;
`endif
   logic                    falling;
   logic                    mid_bit;

   assign falling = rxd_prev_q & ~rxd_s_q;
   assign mid_bit = (cnt_q == CNT_LAST);

   // Two-flop synchroniser plus one delayed copy for start-edge detection; idle-high on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= uart_rxd;
         rxd_s_q    <= rxd_meta_q;
         rxd_prev_q <= rxd_s_q;
      end
   end

   // Frame state, bit timing and registered result pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         brk_q     <= brk_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   // Next-state: walk start/data/(parity)/stop, sampling rxd_s at each bit centre.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_d     = bit_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      brk_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d    = 1'b0;
      par_bad_d = par_bad_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
            // Only a high-to-low transition starts a frame, so a stuck-low line cannot retrigger.
            if (uart_rx_en && falling) begin
               state_d = S_START;
            end
         end
         S_START: begin
            // Half a bit in: still low means a real start bit, high means a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rxd_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (mid_bit) begin
               cnt_d   = '0;
               shift_d = {rxd_s_q, shift_q[PAYLOAD_BITS-1:1]};
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (mid_bit) begin
               cnt_d     = '0;
               par_bad_d = (rxd_s_q != ((^shift_q) ^ PAR_SENSE));
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Back to IDLE on the sample itself so a start edge late in the stop bit is caught.
            if (mid_bit) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (rxd_s_q) begin
`ifdef UART_RX_PARITY_EN
                  if (par_bad_q) begin
                     perr_d = 1'b1;
                  end else begin
                     valid_d = 1'b1;
                     data_d  = shift_q;
                  end
`else
                  valid_d = 1'b1;
                  data_d  = shift_q;
`endif
               end else begin
                  ferr_d = 1'b1;
                  brk_d  = (shift_q == '0);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Disabling the receiver abandons any frame silently.
      if (!uart_rx_en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         bit_d   = '0;
         data_d  = data_q;
         valid_d = 1'b0;
         ferr_d  = 1'b0;
         brk_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_d  = 1'b0;
`endif
      end
   end

   assign uart_rx_valid     = valid_q;
   assign uart_rx_data      = data_q;
   assign uart_rx_frame_err = ferr_q;
   assign uart_rx_break     = brk_q;
`ifdef UART_RX_PARITY_EN
   assign uart_rx_parity_err = perr_q;
`else
   assign uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random frame mixes against a frame-level model.
// Model works per frame (byte, stop level, parity flip, abort) and predicts the single result event.
// Observed pulses are collected by a monitor and compared at idle checkpoints.
module tb_uart_rx;
   localparam int CLK_HZ   = 1_000_000;
   localparam int BIT_RATE = 100_000;
   localparam int CPB      = CLK_HZ / BIT_RATE;
   localparam int PB       = 8;
   localparam bit PODD     = 1'b0;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_EN   = 1;
`else
   localparam int PAR_EN   = 0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          uart_rxd;
   logic          uart_rx_en;
   logic          uart_rx_valid;
   logic [PB-1:0] uart_rx_data;
   logic          uart_rx_frame_err;
   logic          uart_rx_break;
   logic          uart_rx_parity_err;

   uart_rx #(
      .CLK_HZ      (CLK_HZ),
      .BIT_RATE    (BIT_RATE),
      .PAYLOAD_BITS(PB),
      .PARITY_ODD  (0)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .uart_rxd          (uart_rxd),
      .uart_rx_en        (uart_rx_en),
      .uart_rx_valid     (uart_rx_valid),
      .uart_rx_data      (uart_rx_data),
      .uart_rx_frame_err (uart_rx_frame_err),
      .uart_rx_break     (uart_rx_break),
      .uart_rx_parity_err(uart_rx_parity_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // event = {valid, frame_err, break, parity_err, data-if-valid}
   typedef logic [11:0] evt_t;
   evt_t       obs_q[$];
   evt_t       exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         last_valid_cyc = 0;
   int         frame_start_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Collect every result pulse as an event.
   always @(negedge clk) begin
      if (reset_n && (uart_rx_valid || uart_rx_frame_err || uart_rx_break || uart_rx_parity_err)) begin
         obs_q.push_back({uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_parity_err,
                          uart_rx_valid ? uart_rx_data : 8'h00});
         if (uart_rx_valid) last_valid_cyc = cyc;
      end
   end

   // Frame-level reference: what one transmitted frame should produce.
   function automatic void model_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                                       input bit aborted);
      if (aborted) return;
      if (!stop_bit) begin
         exp_q.push_back({1'b0, 1'b1, (b == 8'h00), 1'b0, 8'h00});
      end else if (PAR_EN != 0 && par_flip) begin
         exp_q.push_back({4'b0001, 8'h00});
      end else begin
         exp_q.push_back({4'b1000, b});
         last_good = b;
      end
   endfunction

   task automatic drive_bit(input logic v);
      uart_rxd = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                             input int abort_at);
      frame_start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < PB; i++) begin
         if (i == abort_at) uart_rx_en = 1'b0;
         drive_bit(b[i]);
      end
      if (PAR_EN != 0) drive_bit((^b) ^ PODD ^ par_flip);
      drive_bit(stop_bit);
      uart_rxd = 1'b1;
      if (abort_at >= 0) begin
         repeat (3) @(negedge clk);
         uart_rx_en = 1'b1;
      end
      model_frame(b, stop_bit, par_flip, abort_at >= 0);
   endtask

   task automatic checkpoint(input string tag);
      repeat (CPB) @(negedge clk);
      check({tag, ".count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s.evt%0d", tag, i), obs_q[i], exp_q[i]);
      check({tag, ".data"}, uart_rx_data, last_good);
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int lat_mid;
      reset_n    = 1'b0;
      uart_rxd   = 1'b1;
      uart_rx_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset.flags", {uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_parity_err}, 4'h0);
      check("reset.data", uart_rx_data, 8'h00);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: single good byte, plus latency from start edge to valid
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      lat     = last_valid_cyc - frame_start_cyc;
      lat_mid = (PB + 1 + PAR_EN) * CPB + CPB / 2 + 3;
      check("t1.latency_window", 32'((lat >= lat_mid - 3) && (lat <= lat_mid + 3)), 32'd1);
      checkpoint("t1");

      // 2: short glitch then a good frame
      uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      uart_rxd = 1'b1;
      checkpoint("t2.glitch");
      send_frame(8'h3C, 1'b1, 1'b0, -1);
      checkpoint("t2");

      // 3: bad stop bit keeps previous data
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      checkpoint("t3.pre");
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      checkpoint("t3");

      // 4: long break, then a good frame
      uart_rxd = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      uart_rxd = 1'b1;
      exp_q.push_back({4'b0110, 8'h00});
      checkpoint("t4.break");
      send_frame(8'h5A, 1'b1, 1'b0, -1);
      checkpoint("t4");

      // 5: back-to-back frames, then one aborted by disabling the receiver
      send_frame(8'h00, 1'b1, 1'b0, -1);
      send_frame(8'hFF, 1'b1, 1'b0, -1);
      send_frame(8'h7E, 1'b1, 1'b0, 4);
      checkpoint("t5");

      // 6: parity good / bad (behaves as plain frames when parity is not built in)
      send_frame(8'h81, 1'b1, 1'b0, -1);
      checkpoint("t6.ok");
      send_frame(8'h81, 1'b1, 1'b1, -1);
      checkpoint("t6.flip");

      // reset during a frame discards it and clears data
      uart_rxd = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_mid.outs", {uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_parity_err,
                             uart_rx_data}, 12'h000);
      repeat (2) @(negedge clk);
      uart_rxd  = 1'b1;
      reset_n   = 1'b1;
      last_good = 8'h00;
      obs_q.delete();
      checkpoint("rst_mid");
      send_frame(8'hC3, 1'b1, 1'b0, -1);
      checkpoint("rst_after");

      // random mix
      for (int it = 0; it < 40; it++) begin
         int         kind;
         logic [7:0] b;
         kind = $urandom_range(0, 9);
         b    = 8'($urandom);
         if (kind <= 5) begin
            send_frame(b, 1'b1, 1'b0, -1);
         end else if (kind == 6) begin
            send_frame(b, 1'b0, 1'b0, -1);
            repeat (CPB) @(negedge clk);
         end else if (kind == 7) begin
            send_frame(b, 1'b1, 1'b1, -1);
         end else if (kind == 8) begin
            send_frame(b, 1'b1, 1'b0, int'($urandom_range(0, PB - 1)));
         end else begin
            uart_rxd = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            uart_rxd = 1'b1;
            repeat (CPB) @(negedge clk);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if (it % 4 == 3) checkpoint($sformatf("rnd%0d", it));
      end
      checkpoint("rnd_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
